hamming_dec_pipe: RTL

Pipelined Hamming(15,11) single-error-correcting decoder with valid/ready flow control. It is the receive end of the 15-bit codeword path: it accepts codewords (possibly corrupted on the channel), computes the syndrome, corrects any single-bit error, and delivers the 11 data bits. It also keeps running counts of decoded words and corrections for the verification bench and system status.

---
 rtl/hamming_dec_pipe_if.sv | 25 ++
 rtl/hamming_dec_pipe.sv | 105 ++++++++++
 2 files changed

// File: rtl/hamming_dec_pipe_if.sv
// Valid/ready stream bundle for the Hamming(15,11) decoder: codeword in, corrected data out.
interface hamming_dec_pipe_if;
  localparam int unsigned CW_W   = 15;
  localparam int unsigned DATA_W = 11;
  localparam int unsigned SYN_W  = 4;

  logic              in_valid;
  logic              in_ready;
  logic [CW_W-1:0]   in_cw;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic              out_corrected;
  logic [SYN_W-1:0]  out_syndrome;

  modport master (
    output in_valid, in_cw, out_ready,
    input  in_ready, out_valid, out_data, out_corrected, out_syndrome
  );

  modport slave (
    input  in_valid, in_cw, out_ready,
    output in_ready, out_valid, out_data, out_corrected, out_syndrome
  );
endinterface

// File: rtl/hamming_dec_pipe.sv
// Three-stage Hamming(15,11) single-error-correcting decoder with elastic stall chain
// and handshake counters (word count wraps, correction count saturates).
module hamming_dec_pipe (
  input  logic                clk,
  input  logic                reset,
  hamming_dec_pipe_if.slave   bus,
  input  logic                clr_counts,
  output logic [15:0]         word_count,
  output logic [15:0]         corr_count
);
  localparam int unsigned CW_W   = 15;
  localparam int unsigned DATA_W = 11;
  localparam int unsigned SYN_W  = 4;
  localparam int unsigned CNT_W  = 16;

  // Syndrome is the XOR of the position indices of every set bit.
  function automatic logic [SYN_W-1:0] calc_syn(input logic [CW_W-1:0] cw);
    logic [SYN_W-1:0] s;
    s = '0;
    for (int unsigned i = 1; i <= CW_W; i++) begin
      if (cw[i-1]) s = s ^ SYN_W'(i);
    end
    return s;
  endfunction

  logic                en1, en2, en3;
  logic                v1, v2, v3;
  logic [CW_W-1:0]     cw1, cw2;
  logic [SYN_W-1:0]    syn2;
  logic [CW_W-1:0]     flip_mask_c;
  logic [CW_W-1:0]     fixed_c;
  logic [DATA_W-1:0]   data3;
  logic                corr3;
  logic [SYN_W-1:0]    syn3;
  logic                out_hs;

  assign en3 = !v3 | bus.out_ready;
  assign en2 = !v2 | en3;
  assign en1 = !v1 | en2;

  assign bus.in_ready      = en1;
  assign bus.out_valid     = v3;
  assign bus.out_data      = data3;
  assign bus.out_corrected = corr3;
  assign bus.out_syndrome  = syn3;

  always_comb begin
    flip_mask_c = '0;
    if (syn2 != '0) flip_mask_c = CW_W'(1) << (syn2 - SYN_W'(1));
    fixed_c = cw2 ^ flip_mask_c;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      v1  <= 1'b0;
      cw1 <= '0;
    end else if (en1) begin
      v1  <= bus.in_valid;
      cw1 <= bus.in_cw;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      v2   <= 1'b0;
      cw2  <= '0;
      syn2 <= '0;
    end else if (en2) begin
      v2   <= v1;
      cw2  <= cw1;
      syn2 <= calc_syn(cw1);
    end
  end

  // Data bits live at positions 3,5-7,9-15 (vector bits 2,4-6,8-14).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      v3    <= 1'b0;
      data3 <= '0;
      corr3 <= 1'b0;
      syn3  <= '0;
    end else if (en3) begin
      v3    <= v2;
      data3 <= {fixed_c[14:8], fixed_c[6:4], fixed_c[2]};
      corr3 <= (syn2 != '0);
      syn3  <= syn2;
    end
  end

  assign out_hs = v3 & bus.out_ready;

  // Clear wins over a same-cycle handshake.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      word_count <= '0;
      corr_count <= '0;
    end else if (clr_counts) begin
      word_count <= '0;
      corr_count <= '0;
    end else if (out_hs) begin
      word_count <= word_count + CNT_W'(1);
      if (corr3 && (corr_count != '1)) corr_count <= corr_count + CNT_W'(1);
    end
  end
endmodule
